// File: rtl/dc_checkerboard.sv
// dc_checkerboard: regenerates the two-pass checkerboard read stream, counts mismatches and reports a verdict.
// Optional first-error capture is built when DC_CHECKERBOARD_FIRST_ERR_EN is defined.
module dc_checkerboard #(
    parameter int WIDTH         = 8,
    parameter int LENGTH        = 512,
    parameter int INVERT_VALUES = 0,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      start_i,
    input  logic [WIDTH-1:0]          rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
    output logic [$clog2(LENGTH)-1:0] first_err_idx_o,
    output logic                      first_err_pass_o,
    output logic [WIDTH-1:0]          first_err_data_o
);
    localparam int IW = $clog2(LENGTH);

    function automatic logic [WIDTH-1:0] base_f();
        logic [WIDTH-1:0] b;
        for (int i = 0; i < WIDTH; i++) b[i] = ((i % 2) == 1) ^ (INVERT_VALUES != 0);
        return b;
    endfunction

    localparam logic [WIDTH-1:0] BASE = base_f();

    typedef enum logic [1:0] {IDLE, CHECK, FLUSH, DONE} state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic [IW-1:0]            r_word_cnt;
    logic                     r_pass_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_err;
    logic                     r_cmp_valid;
    logic                     r_cmp_last;
    logic [WIDTH-1:0]         r_cmp_data;
    logic [WIDTH-1:0]         r_cmp_exp;
    logic                     w_wrap;
    logic                     w_last;
    logic                     w_mis;
    logic [WIDTH-1:0]         w_exp;
    logic [ERR_CNT_WIDTH-1:0] w_err_next;

    always_comb begin
        w_wrap     = r_word_cnt == IW'(LENGTH - 1);
        w_last     = r_pass_cnt && w_wrap;
        w_exp      = (r_word_cnt[0] ^ r_pass_cnt) ? ~BASE : BASE;
        w_mis      = r_cmp_valid && (r_cmp_data != r_cmp_exp);
        w_err_next = (w_mis && !(&r_err)) ? r_err + 1'b1 : r_err;
    end

`ifdef DC_CHECKERBOARD_FIRST_ERR_EN
    logic [IW-1:0]    r_cmp_idx;
    logic             r_cmp_pass;
    logic             r_seen;
    logic [IW-1:0]    r_fe_idx;
    logic             r_fe_pass;
    logic [WIDTH-1:0] r_fe_data;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cmp_idx  <= '0;
            r_cmp_pass <= 1'b0;
            r_seen     <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_pass  <= 1'b0;
            r_fe_data  <= '0;
        end else begin
            if (r_state == CHECK && rd_valid_i) begin
                r_cmp_idx  <= r_word_cnt;
                r_cmp_pass <= r_pass_cnt;
            end
            if ((r_state == IDLE || r_state == DONE) && start_i) begin
                r_seen    <= 1'b0;
                r_fe_idx  <= '0;
                r_fe_pass <= 1'b0;
                r_fe_data <= '0;
            end else if (w_mis && !r_seen) begin
                r_seen    <= 1'b1;
                r_fe_idx  <= r_cmp_idx;
                r_fe_pass <= r_cmp_pass;
                r_fe_data <= r_cmp_data;
            end
        end
    end

    assign first_err_idx_o  = r_fe_idx;
    assign first_err_pass_o = r_fe_pass;
    assign first_err_data_o = r_fe_data;
`else
    assign first_err_idx_o  = '0;
    assign first_err_pass_o = 1'b0;
    assign first_err_data_o = '0;
`endif

    // The compare stage retires every cycle; a new beat only enters it in CHECK.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_word_cnt  <= '0;
            r_pass_cnt  <= 1'b0;
            r_err       <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_last  <= 1'b0;
            r_cmp_data  <= '0;
            r_cmp_exp   <= '0;
        end else begin
            r_cmp_valid <= 1'b0;
            r_err       <= w_err_next;
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state    <= CHECK;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_word_cnt <= '0;
                        r_pass_cnt <= 1'b0;
                        r_err      <= '0;
                        r_cmp_last <= 1'b0;
                    end
                end
                CHECK: begin
                    if (rd_valid_i) begin
                        r_cmp_valid <= 1'b1;
                        r_cmp_last  <= w_last;
                        r_cmp_data  <= rd_data_i;
                        r_cmp_exp   <= w_exp;
                        r_word_cnt  <= w_wrap ? '0 : r_word_cnt + 1'b1;
                        r_pass_cnt  <= r_pass_cnt ^ w_wrap;
                        if (w_last) r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_cmp_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_err_next == '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign err_cnt_o = r_err;
endmodule

// File: doc/dc_checkerboard.md
# dc_checkerboard

Read-back checker for the checkerboard test pattern in the eMMC verification environment. Sits directly downstream of the checkerboard write-pattern generator, on the read-data path of the card model or DUT. It independently regenerates the expected read data for the two read passes that follow the generator's two write passes. It compares each returned word, counts mismatches and reports a pass/fail verdict when all words are consumed.

## Interface
- WIDTH, 8, data word width in bits.
- LENGTH, 512, words per pass; must be ≥ 2; counter width $clog2(LENGTH).
- INVERT_VALUES, 0, 0: base pattern 'haaaa…; 1: base pattern 'h5555… (truncated to WIDTH).
- ERR_CNT_WIDTH, 16, mismatch counter width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- arst_n_i  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  begin a check run; honoured only in IDLE or DONE.
- rd_data_i  in  WIDTH  read data word.
- rd_valid_i  in  1  rd_data_i valid this cycle; no backpressure.
- busy_o  out  1  high in CHECK and FLUSH.
- done_o  out  1  high in DONE.
- pass_o  out  1  valid while done_o; 1 when err_cnt_o == 0.
- err_cnt_o  out  ERR_CNT_WIDTH  saturating mismatch count.
- first_err_idx_o  out  $clog2(LENGTH)  word index of first mismatch.
- first_err_pass_o  out  1  pass (0/1) of first mismatch.
- first_err_data_o  out  WIDTH  received data of first mismatch.

## Operation
- Base value B = INVERT_VALUES ? 'h55… : 'haa…. Expected word k, pass p is B when (k[0] ^ p) == 0; otherwise ~B.
- FSM states are IDLE, CHECK, FLUSH and DONE.
- IDLE: start_i → CHECK. Clears word_cnt, pass_cnt, err_cnt_o and the first-error fields, and clears the first-error-seen flag.
- CHECK: each rd_valid_i beat is registered into a compare stage along with data, expected value, index, pass and a last flag. word_cnt is then incremented. At word_cnt == LENGTH-1, word_cnt wraps to 0 and pass_cnt toggles.
- The beat with pass_cnt == 1 and word_cnt == LENGTH-1 is the last beat. CHECK → FLUSH.
- FLUSH: the compare stage retires the last beat, then the FSM moves to DONE. rd_valid_i is ignored.
- Compare stage on a valid entry with data ≠ expected: err_cnt_o increments, saturating at all-ones. If no error has been seen yet, the first-error fields are loaded and the seen flag is set.
- DONE: outputs hold. start_i → CHECK with the same clears as from IDLE.
- start_i in CHECK or FLUSH is ignored. rd_valid_i in IDLE or DONE is ignored.
- Reset at any time returns to IDLE with every output 0 within the reset assertion; no partial state survives.

## Timing
- Reset values: busy_o = 0, done_o = 0, pass_o = 0, err_cnt_o = 0, all first_err_* = 0.
- start_i sampled high at edge N: busy_o is high after N, and the first beat is accepted at edge N+1 or later.
- Beat sampled at edge M: its err_cnt_o and first-error effect is visible after edge M+1.
- Last beat sampled at edge M: FLUSH after M, DONE/done_o and final pass_o after M+1, busy_o low after M+1.
- Back-to-back beats every cycle are supported.
- Gaps in rd_valid_i are allowed with no limit.
- There is no timeout.
- pass_o is registered in the same edge that enters DONE. It is never high while busy_o is high.

## Configuration
- Macro DC_CHECKERBOARD_FIRST_ERR_EN.
- Defined: first-error capture is built as described.
- Undefined: the capture registers and seen flag are not built. first_err_idx_o, first_err_pass_o and first_err_data_o are tied to 0. Counting and verdict are unchanged.

## Test plan
Parameters for all scenarios: WIDTH=8, LENGTH=4, INVERT_VALUES=0.
- Clean run: start, then beats AA,55,AA,55,55,AA,55,AA on consecutive cycles → done_o two edges after the last beat, pass_o=1, err_cnt_o=0.
- Single error: as the clean run, but word 2 of pass 1 is 00 → err_cnt_o=1, pass_o=0, first_err_idx_o=2, first_err_pass_o=1, first_err_data_o=00 (0 when the macro is undefined).
- Gaps and saturation: beats with random valid gaps, all data FF, ERR_CNT_WIDTH=2 → err_cnt_o=3 (saturated), first_err_idx_o=0, first_err_pass_o=0, first_err_data_o=FF.
- Inverted pattern: INVERT_VALUES=1 with stream 55,AA,55,AA,AA,55,AA,55 → pass_o=1. The non-inverted stream gives err_cnt_o=8.
- Reset mid-run: arst_n_i low after 3 beats → all outputs 0 immediately. A new start_i then completes a clean run with pass_o=1.
- Restart and ignore rules: start_i pulsed during CHECK has no effect. start_i in DONE clears err_cnt_o to 0 and raises busy_o on the next edge.
